// File: rtl/regfile_decoded_nport.sv
// regfile_decoded_nport
// General-purpose register file: one write port with an internal one-hot
// address decoder, two independent combinational read ports, optional
// same-cycle write-to-read bypass and optional hardwired-zero register 0.
module regfile_decoded_nport #(
    parameter int ADDR_W   = 5,
    parameter int WIDTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_W-1:0]    raddr_a,
    input  logic [ADDR_W-1:0]    raddr_b,
    output logic [WIDTH-1:0]     rdata_a,
    output logic [WIDTH-1:0]     rdata_b,
    output logic [2**ADDR_W-1:0] wen_oh
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [WIDTH-1:0] regs [DEPTH];
    logic             zero_target;
    logic             byp_a;
    logic             byp_b;

    // A write aimed at the hardwired-zero register is never performed or forwarded
    always_comb begin
        zero_target = (ZERO_REG != 0) && (waddr == '0);
    end

    // One-hot write decode; gated by reset so nothing is written while it is held
    always_comb begin
        wen_oh = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wen_oh[i] = we && reset_n && (waddr == ADDR_W'(i));
        end
        if (ZERO_REG != 0) begin
            wen_oh[0] = 1'b0;
        end
    end

    // Register array: async clear, then each decoded register loads wdata
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wen_oh[i]) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    // Bypass hit detection per read port
    always_comb begin
        byp_a = (BYPASS != 0) && we && reset_n && !zero_target && (raddr_a == waddr);
        byp_b = (BYPASS != 0) && we && reset_n && !zero_target && (raddr_b == waddr);
    end

    // Read port A: reset forces 0, then zero register, then bypass, then array
    always_comb begin
        rdata_a = '0;
        if (!reset_n) begin
            rdata_a = '0;
        end else if ((ZERO_REG != 0) && (raddr_a == '0)) begin
            rdata_a = '0;
        end else if (byp_a) begin
            rdata_a = wdata;
        end else begin
            rdata_a = regs[raddr_a];
        end
    end

    // Read port B: same priority as port A, fully independent
    always_comb begin
        rdata_b = '0;
        if (!reset_n) begin
            rdata_b = '0;
        end else if ((ZERO_REG != 0) && (raddr_b == '0)) begin
            rdata_b = '0;
        end else if (byp_b) begin
            rdata_b = wdata;
        end else begin
            rdata_b = regs[raddr_b];
        end
    end

endmodule

// File: tb/tb_regfile_decoded_nport.sv
// Scoreboard bench for regfile_decoded_nport. Two instances share stimulus:
// one with ZERO_REG=1/BYPASS=1, one with ZERO_REG=0/BYPASS=0. Stimulus pushes
// the expected outputs of a plain array model; a monitor pops at the falling edge.
module tb_regfile_decoded_nport;

    logic        clock;
    logic        reset_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    logic [31:0] ra1, rb1, wen1;
    logic [31:0] ra0, rb0, wen0;

    typedef struct {
        string       name;
        logic [31:0] a1, b1, w1;
        logic [31:0] a0, b0, w0;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem1 [32];
    logic [31:0] mem0 [32];
    int          errors = 0;
    int          checks = 0;

    regfile_decoded_nport #(.ADDR_W(5), .WIDTH(32), .ZERO_REG(1), .BYPASS(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra1), .rdata_b(rb1), .wen_oh(wen1)
    );

    regfile_decoded_nport #(.ADDR_W(5), .WIDTH(32), .ZERO_REG(0), .BYPASS(0)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra0), .rdata_b(rb0), .wen_oh(wen0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: value a read port shows under the current inputs
    function automatic logic [31:0] exp_rd(input bit zero, input bit byp, input logic [4:0] ra);
        if (!reset_n) return 32'h0;
        if (zero && ra == 5'd0) return 32'h0;
        if (byp && we && ra == waddr) return wdata;
        return zero ? mem1[ra] : mem0[ra];
    endfunction

    function automatic logic [31:0] exp_wen(input bit zero);
        logic [31:0] v;
        v = 32'h0;
        if (reset_n && we && !(zero && waddr == 5'd0)) v[waddr] = 1'b1;
        return v;
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < 32; i++) begin
            mem1[i] = 32'h0;
            mem0[i] = 32'h0;
        end
    endfunction

    task automatic push_exp(input string name);
        exp_t e;
        e.name = name;
        e.a1 = exp_rd(1'b1, 1'b1, raddr_a);
        e.b1 = exp_rd(1'b1, 1'b1, raddr_b);
        e.w1 = exp_wen(1'b1);
        e.a0 = exp_rd(1'b0, 1'b0, raddr_a);
        e.b0 = exp_rd(1'b0, 1'b0, raddr_b);
        e.w0 = exp_wen(1'b0);
        sb.push_back(e);
    endtask

    // Drive one cycle (called just after a rising edge), then commit the model write
    task automatic step(input string name, input logic rst, input logic w, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
        reset_n = rst;
        we      = w;
        waddr   = wa;
        wdata   = wd;
        raddr_a = ra;
        raddr_b = rb;
        if (!rst) clear_model();
        push_exp(name);
        @(posedge clock);
        if (reset_n && we) begin
            if (waddr != 5'd0) mem1[waddr] = wdata;
            mem0[waddr] = wdata;
        end
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are stable at the falling edge; compare against the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({e.name, ".rdata_a(Z1B1)"}, ra1, e.a1);
                chk({e.name, ".rdata_b(Z1B1)"}, rb1, e.b1);
                chk({e.name, ".wen_oh(Z1B1)"}, wen1, e.w1);
                chk({e.name, ".rdata_a(Z0B0)"}, ra0, e.a0);
                chk({e.name, ".rdata_b(Z0B0)"}, rb0, e.b0);
                chk({e.name, ".wen_oh(Z0B0)"}, wen0, e.w0);
            end
        end
    end

    initial begin
        logic [4:0]  wa, ra, rb;
        logic [31:0] wd;
        int          waits;
        reset_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        clear_model();
        @(posedge clock); #1;

        // Reset held across an edge with a write pending
        step("reset_hold", 1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd3);
        step("reset_after", 1'b1, 1'b0, 5'd3, 32'h0, 5'd3, 5'd3);

        // Write every index 1..31, then read back on both ports
        for (int i = 1; i < 32; i++)
            step("write_all", 1'b1, 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'(i), 5'(31 - i));
        for (int i = 0; i < 32; i++)
            step("readback", 1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

        // Write to register 0
        step("zero_write", 1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        step("zero_after", 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        // Bypass vs. no bypass on register 7
        step("byp_setup", 1'b1, 1'b1, 5'd7, 32'h11, 5'd1, 5'd2);
        step("byp_same", 1'b1, 1'b1, 5'd7, 32'h22, 5'd7, 5'd7);
        step("byp_after", 1'b1, 1'b0, 5'd7, 32'h0, 5'd7, 5'd7);

        // we low with varying address/data
        for (int i = 0; i < 10; i++) begin
            ra = 5'($urandom_range(0, 31));
            step("we_low", 1'b1, 1'b0, 5'($urandom_range(0, 31)), $urandom, ra, ~ra);
        end
        for (int i = 0; i < 32; i++)
            step("we_low_rb", 1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i));

        // Random traffic, biased so reads often hit the written index
        for (int i = 0; i < 300; i++) begin
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            step("random", 1'b1, 1'($urandom_range(0, 1)), wa, wd, ra, rb);
        end

        // Mid-run reset pulse shorter than a clock period between edges
        reset_n = 1'b0; we = 1'b0; raddr_a = 5'd9; raddr_b = 5'd17;
        clear_model();
        push_exp("mid_reset");
        #6 reset_n = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < 32; i++)
            step("post_reset", 1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
        step("post_wr5", 1'b1, 1'b1, 5'd5, 32'hA5, 5'd4, 5'd6);
        step("post_rd5", 1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);

        waits = 0;
        while (sb.size() != 0 && waits < 10) begin
            @(negedge clock); #1;
            waits++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
